// File: rtl/spi_responder.sv
// ============================================================================
// spi_responder : SPI Mode 0 responder with byte-wide register memory,
//                 single/burst read and write, synchronized SPI inputs.
// Revision 1.0  : initial release
// ============================================================================
`default_nettype none

module spi_responder #(
  parameter int ADDR_WIDTH  = 7,
  parameter int SYNC_STAGES = 2
) (
  input  logic CLK,
  input  logic reset,
  input  logic SCLK,
  input  logic CS,
  input  logic MOSI,
  output logic MISO,
  output logic MISO_oe,
  output logic wr_strobe,
  output logic busy
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CMD  = 2'd1;
  localparam logic [1:0] S_RD   = 2'd2;
  localparam logic [1:0] S_WR   = 2'd3;

  // --------------------------------------------------------------------------
  // Input conditioning
  // --------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sclk_sync_q;
  logic [SYNC_STAGES-1:0] cs_sync_q;
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic                   sclk_prev_q;
  logic                   cs_prev_q;

  // CS chain resets to the inactive (high) level so busy starts low.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      sclk_prev_q <= 1'b0;
      cs_prev_q   <= 1'b1;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], SCLK};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], CS};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], MOSI};
      sclk_prev_q <= sclk_sync_q[SYNC_STAGES-1];
      cs_prev_q   <= cs_sync_q[SYNC_STAGES-1];
    end
  end

  logic sclk_s;
  logic cs_s;
  logic mosi_s;
  logic sclk_rise;
  logic sclk_fall;
  logic cs_fall;
  logic cs_rise;

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;
  assign cs_fall   = ~cs_s & cs_prev_q;
  assign cs_rise   = cs_s & ~cs_prev_q;

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  logic [1:0]            state_q, state_d;
  logic [2:0]            bit_cnt_q, bit_cnt_d;
  logic [6:0]            rx_q, rx_d;
  logic [7:0]            tx_q, tx_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  miso_q, miso_d;
  logic                  wr_strobe_q, wr_strobe_d;
  logic                  mem_we;
  logic [7:0]            mem_q [DEPTH];

  logic [7:0]            new_byte;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [ADDR_WIDTH-1:0] addr_inc;
  logic                  last_bit;

  assign new_byte = {rx_q, mosi_s};
  assign cmd_addr = new_byte[7 -: ADDR_WIDTH];
  assign addr_inc = addr_q + ADDR_WIDTH'(1);
  assign last_bit = (bit_cnt_q == 3'd7);

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // cs_rise takes priority over any serial edge seen in the same cycle.
  always_comb begin
    state_d = state_q;
    if (cs_rise) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: if (cs_fall) state_d = S_CMD;
        S_CMD: begin
          if (sclk_rise && last_bit) begin
            state_d = new_byte[0] ? S_RD : S_WR;
          end
        end
        S_RD:    state_d = S_RD;
        S_WR:    state_d = S_WR;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    bit_cnt_d   = bit_cnt_q;
    rx_d        = rx_q;
    tx_d        = tx_q;
    addr_d      = addr_q;
    miso_d      = miso_q;
    wr_strobe_d = 1'b0;
    mem_we      = 1'b0;
    if (cs_rise) begin
      bit_cnt_d = 3'd0;
      rx_d      = 7'd0;
      miso_d    = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cs_fall) begin
            bit_cnt_d = 3'd0;
            rx_d      = 7'd0;
            miso_d    = 1'b0;
          end
        end
        S_CMD: begin
          if (sclk_rise) begin
            rx_d      = new_byte[6:0];
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (last_bit) begin
              addr_d = cmd_addr;
              tx_d   = mem_q[cmd_addr];
            end
          end
        end
        S_RD: begin
          // The byte boundary reloads from the next address so bursts stream.
          if (sclk_fall) begin
            miso_d    = tx_q[7];
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (last_bit) begin
              addr_d = addr_inc;
              tx_d   = mem_q[addr_inc];
            end else begin
              tx_d = {tx_q[6:0], 1'b0};
            end
          end
        end
        S_WR: begin
          if (sclk_rise) begin
            rx_d      = new_byte[6:0];
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (last_bit) begin
              mem_we      = 1'b1;
              wr_strobe_d = 1'b1;
              addr_d      = addr_inc;
            end
          end
        end
        default: begin
          bit_cnt_d = 3'd0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      bit_cnt_q   <= 3'd0;
      rx_q        <= 7'd0;
      tx_q        <= 8'h00;
      addr_q      <= '0;
      miso_q      <= 1'b0;
      wr_strobe_q <= 1'b0;
    end else begin
      bit_cnt_q   <= bit_cnt_d;
      rx_q        <= rx_d;
      tx_q        <= tx_d;
      addr_q      <= addr_d;
      miso_q      <= miso_d;
      wr_strobe_q <= wr_strobe_d;
    end
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 8'h00;
      end
    end else if (mem_we) begin
      mem_q[addr_q] <= new_byte;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  always_comb begin
    MISO_oe   = (state_q != S_IDLE);
    MISO      = (state_q == S_RD) & miso_q;
    wr_strobe = wr_strobe_q;
    busy      = ~cs_s;
  end

endmodule

`default_nettype wire

// File: tb/tb_spi_responder.sv
// ============================================================================
// tb_spi_responder : randomized scoreboard bench for spi_responder.
// Revision 1.0     : initial release
// ============================================================================
`default_nettype none

module tb_spi_responder;

  localparam int AW    = 7;
  localparam int SS    = 2;
  localparam int DEPTH = 128;

  logic clk  = 1'b0;
  logic rst  = 1'b1;
  logic sclk = 1'b0;
  logic cs   = 1'b1;
  logic mosi = 1'b0;
  logic miso;
  logic miso_oe;
  logic wr_strobe;
  logic busy;

  spi_responder #(.ADDR_WIDTH(AW), .SYNC_STAGES(SS)) dut (
    .CLK      (clk),
    .reset    (rst),
    .SCLK     (sclk),
    .CS       (cs),
    .MOSI     (mosi),
    .MISO     (miso),
    .MISO_oe  (miso_oe),
    .wr_strobe(wr_strobe),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int         pass_cnt  = 0;
  int         total_cnt = 0;
  int         ph        = 6;
  int         obs_wr    = 0;
  int         exp_wr    = 0;
  logic [7:0] model [DEPTH];
  logic [7:0] exp_q [$];
  logic [7:0] wq [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bits(input logic [7:0] b, input int nbits);
    for (int i = 7; i > 7 - nbits; i--) begin
      mosi = b[i];
      clks(ph);
      sclk = 1'b1;
      clks(ph);
      sclk = 1'b0;
    end
  endtask

  task automatic cs_assert();
    cs = 1'b0;
    clks(ph);
  endtask

  task automatic cs_release();
    clks(ph);
    cs = 1'b1;
    clks(SS + 2);
    check("oe_after_cs_rise", miso_oe, 1'b0);
    check("busy_after_cs_rise", busy, 1'b0);
    clks(ph);
  endtask

  // Writes the bytes queued in wq as one burst starting at a.
  task automatic wr_burst(input logic [6:0] a);
    logic [6:0] p;
    p = a;
    cs_assert();
    send_bits({a, 1'b0}, 8);
    foreach (wq[i]) begin
      send_bits(wq[i], 8);
      model[p] = wq[i];
      p++;
      exp_wr++;
    end
    check("miso_low_in_wr", miso, 1'b0);
    check("oe_in_wr", miso_oe, 1'b1);
    check("busy_in_wr", busy, 1'b1);
    cs_release();
    check("wr_strobe_count", obs_wr, exp_wr);
    wq.delete();
  endtask

  task automatic rd_burst(input logic [6:0] a, input int n);
    logic [6:0] p;
    p = a;
    cs_assert();
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(model[p]);
      p++;
    end
    send_bits({a, 1'b1}, 8);
    check("oe_in_rd", miso_oe, 1'b1);
    for (int i = 0; i < n; i++) send_bits(8'($urandom), 8);
    cs_release();
  endtask

  // Monitor: decodes the bus as the initiator sees it, scoring read bytes.
  initial begin
    int         nb;
    logic [7:0] cmd;
    logic [7:0] sh;
    nb  = 0;
    cmd = 8'h00;
    sh  = 8'h00;
    forever begin
      @(posedge sclk or posedge cs);
      if (cs) begin
        nb = 0;
      end else begin
        if (nb < 8) cmd = {cmd[6:0], mosi};
        else sh = {sh[6:0], miso};
        nb++;
        if (nb >= 16 && (nb % 8) == 0 && cmd[0]) begin
          if (exp_q.size() == 0) begin
            total_cnt++;
            $display("FAIL rd_unexpected: got %0h expected none", sh);
          end else begin
            check("rd_byte", sh, exp_q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (wr_strobe === 1'b1) obs_wr++;
    end
  end

  initial begin
    logic [6:0] a;
    int         n;
    for (int i = 0; i < DEPTH; i++) model[i] = 8'h00;

    clks(3);
    check("rst_miso", miso, 1'b0);
    check("rst_oe", miso_oe, 1'b0);
    check("rst_wr_strobe", wr_strobe, 1'b0);
    check("rst_busy", busy, 1'b0);
    rst = 1'b0;
    clks(4);

    // Read after reset, single write/read, burst with wrap.
    rd_burst(7'h05, 1);
    wq.push_back(8'hA5);
    wr_burst(7'h10);
    rd_burst(7'h10, 1);
    wq.push_back(8'h11);
    wq.push_back(8'h22);
    wr_burst(7'h7F);
    rd_burst(7'h7F, 2);
    rd_burst(7'h00, 1);

    // Abort a write after five data bits.
    wq.push_back(8'h5A);
    wr_burst(7'h20);
    cs_assert();
    send_bits({7'h20, 1'b0}, 8);
    send_bits(8'hFF, 5);
    cs_release();
    check("abort_no_strobe", obs_wr, exp_wr);
    rd_burst(7'h20, 1);

    // Randomized mixed traffic at varying SCLK phase lengths.
    for (int t = 0; t < 10; t++) begin
      ph = $urandom_range(7, SS + 2);
      a  = 7'($urandom);
      n  = $urandom_range(3, 1);
      if ($urandom_range(1, 0) == 1) begin
        for (int k = 0; k < n; k++) wq.push_back(8'($urandom));
        wr_burst(a);
      end else begin
        rd_burst(a, n);
      end
    end
    ph = 6;

    // Asynchronous reset in the middle of a burst read.
    wq.push_back(8'h33);
    wr_burst(7'h40);
    cs_assert();
    exp_q.push_back(model[7'h40]);
    send_bits({7'h40, 1'b1}, 8);
    send_bits(8'h00, 8);
    send_bits(8'h00, 3);
    sclk = 1'b1;
    clks(2);
    #2 rst = 1'b1;
    #1;
    check("arst_miso", miso, 1'b0);
    check("arst_oe", miso_oe, 1'b0);
    check("arst_busy", busy, 1'b0);
    clks(2);
    rst  = 1'b0;
    sclk = 1'b0;
    clks(ph);
    cs = 1'b1;
    clks(2 * ph);
    for (int i = 0; i < DEPTH; i++) model[i] = 8'h00;
    rd_burst(7'h40, 1);
    rd_burst(7'h10, 1);

    // Minimum legal SCLK phase, every address written then read back.
    ph = SS + 2;
    for (int i = 0; i < DEPTH; i++) wq.push_back(8'($urandom));
    wr_burst(7'h00);
    rd_burst(7'h00, DEPTH);

    check("exp_q_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/spi_responder.md
Name: spi_responder

Overview:
- SPI Mode 0 peripheral (responder) that sits at the far end of the link from the team's SPI initiator block.
- Accepts serial command/data on MOSI, qualified by active-low CS and SCLK, both driven by the initiator.
- Holds an internal byte-wide register memory; services single and burst reads and writes, returning read data on MISO.
- All SPI inputs are asynchronous to CLK and are conditioned internally: synchronizer followed by edge detect.

Parameters:
- ADDR_WIDTH, 7, address bits; memory depth is 2**ADDR_WIDTH bytes.
- SYNC_STAGES, 2, synchronizer flops on SCLK, CS and MOSI (minimum 2).

Ports:
- CLK  input  1  system clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-high reset.
- SCLK  input  1  raw serial clock from initiator.
- CS  input  1  raw chip select from initiator, active low.
- MOSI  input  1  raw serial data from initiator.
- MISO  output  1  serial read data to initiator.
- MISO_oe  output  1  high while MISO should be driven; the top level tri-states MISO when this is low.
- wr_strobe  output  1  one-CLK pulse when a memory byte is written.
- busy  output  1  high while CS (synchronized) is asserted.

Behaviour:
- Reset values: MISO=0, MISO_oe=0, wr_strobe=0, busy=0, FSM=IDLE, bit counter=0, all memory bytes=8'h00.
- Conditioning and latency: each raw input passes through SYNC_STAGES flops. Edge pulses (sclk_rise, sclk_fall, cs_fall, cs_rise) last one CLK and fire SYNC_STAGES+1 cycles after the raw edge.
- Timing requirement on the initiator: SCLK high and low phases each >= SYNC_STAGES+2 CLK periods. Behaviour is undefined if this is violated.
- Bit order and phase: MSB first. MOSI is sampled on sclk_rise. MISO is updated on sclk_fall.
- Command byte: bits[7:1] = address (upper ADDR_WIDTH bits), bit[0] = 1 for read, 0 for write.
- FSM states:
  - IDLE: MISO_oe=0. On cs_fall, go to CMD with bit counter cleared.
  - CMD: shift 8 bits. On the 8th sclk_rise, latch address and rw.
    - Read: load mem[address] into the transmit shifter. On the following sclk_fall, drive its MSB on MISO. Go to RD.
    - Write: go to WR.
  - RD: on each sclk_fall, shift out the next bit. After 8 bits, increment address, reload the shifter from the new address, and continue (burst read).
  - WR: shift in 8 bits on sclk_rise. On the 8th bit, write mem[address] in that same CLK cycle, pulse wr_strobe, increment address, and continue (burst write).
- MISO_oe is 1 from cs_fall until cs_rise, in every state. MISO is 0 outside RD.
- Address wrap: incrementing past 2**ADDR_WIDTH-1 wraps to 0.
- CS deassert (cs_rise) in any state: return to IDLE, clear bit counter, drop MISO_oe, discard any partial byte (no write, no wr_strobe). Completed bytes already written are retained.
- cs_fall while not in IDLE (glitch shorter than the sync window) is ignored.
- sclk edges while in IDLE are ignored.
- Simultaneous cs_rise and the 8th sclk_rise in the same CLK cycle: cs_rise wins and no write occurs.
- Asynchronous reset mid-transfer: everything returns to reset values immediately, including memory.
- busy equals the inverse of synchronized CS.

Test Plan:
- Reset then single read: read command for address 0x05 -> MISO shifts 8'h00; MISO_oe=1 during CS low and 0 within SYNC_STAGES+2 CLK of CS rising.
- Single write then read: write 8'hA5 to address 0x10, raise CS, then read 0x10 -> wr_strobe pulses exactly once; MISO returns 8'hA5 MSB first (bits 1,0,1,0,0,1,0,1).
- Burst write with wrap: write at address 0x7F with data 8'h11, 8'h22 -> mem[0x7F]=8'h11, mem[0x00]=8'h22, two wr_strobe pulses; a burst read from 0x7F returns 8'h11 then 8'h22.
- Abort mid-byte: write command to 0x20, 5 data bits, then CS high -> no wr_strobe and mem[0x20] unchanged. The next transaction decodes correctly from the first bit.
- Async reset mid-burst-read: assert reset between SCLK edges -> MISO=0, MISO_oe=0, busy=0 immediately. A previously written location reads 8'h00 afterwards.
- Minimum SCLK timing: run at exactly SYNC_STAGES+2 CLK per phase with random data to all 128 addresses -> read-back matches every byte.
